ptn_seq_ctrl: RTL and testbench

Countdown sequencer and row-scan controller for the 16×16 LED dot-matrix digit display. It drives the 4-bit `mode` input of the column-pattern selector with digits 9 down to 4, holding each digit for a programmable number of display frames. It also generates the one-hot row strobe, so column patterns and row scanning stay frame-aligned. Digit changes happen only on frame boundaries, which prevents tearing.

---
 rtl/ptn_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_ptn_seq_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ptn_seq_ctrl.sv
// Countdown sequencer and row-scan controller for the 16x16 dot-matrix digit display.
// Steps mode 9..4 on frame boundaries while driving a continuously rotating one-hot row strobe.
module ptn_seq_ctrl #(
   parameter int unsigned TICK_DIV         = 1000,
   parameter int unsigned FRAMES_PER_DIGIT = 60
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        pause,
   input  logic        loop_en,
   output logic [3:0]  mode,
   output logic [15:0] row,
   output logic [3:0]  row_idx,
   output logic        busy,
   output logic        done
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned DW = $clog2(FRAMES_PER_DIGIT) + 1;

   localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DWELL_MAX   = DW'(FRAMES_PER_DIGIT - 1);
   localparam logic [3:0]    DIGIT_FIRST = 4'd9;
   localparam logic [3:0]    DIGIT_LAST  = 4'd4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StPause,
      StDone
   } state_e;

   logic [PW-1:0] presc_q;
   logic [15:0]   row_q;
   logic [3:0]    row_idx_q;
   logic          tick;
   logic          fend;

   state_e        state_q, state_d;
   logic [3:0]    mode_q, mode_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          done_q, done_d;

   assign tick = (presc_q == PRESC_MAX);
   assign fend = tick && (row_idx_q == 4'd15);

   // Prescaler and row scan run in every state so the display never stops refreshing.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q   <= '0;
         row_q     <= 16'h0001;
         row_idx_q <= 4'd0;
      end else begin
         if (tick) begin
            presc_q   <= '0;
            row_q     <= {row_q[14:0], row_q[15]};
            row_idx_q <= row_idx_q + 4'd1;
         end else begin
            presc_q <= presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         mode_q  <= DIGIT_FIRST;
         dwell_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         dwell_q <= dwell_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      dwell_d = dwell_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            mode_d = DIGIT_FIRST;
            if (start) begin
               dwell_d = '0;
               state_d = StRun;
            end
         end

         StRun: begin
            if (fend) begin
               if (dwell_q == DWELL_MAX) begin
                  dwell_d = '0;
                  if (mode_q > DIGIT_LAST) begin
                     mode_d = mode_q - 4'd1;
                  end else if (loop_en) begin
                     mode_d = DIGIT_FIRST;
                  end else begin
                     state_d = StDone;
                     done_d  = 1'b1;
                  end
               end else begin
                  dwell_d = dwell_q + DW'(1);
               end
            end
            // The frame update above lands first; a finished countdown is not paused.
            if (pause && (state_d == StRun)) begin
               state_d = StPause;
            end
         end

         StPause: begin
            if (pause) begin
               state_d = StRun;
            end
         end

         StDone: begin
            mode_d = DIGIT_LAST;
            if (start) begin
               mode_d  = DIGIT_FIRST;
               dwell_d = '0;
               state_d = StRun;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign mode    = mode_q;
   assign row     = row_q;
   assign row_idx = row_idx_q;
   assign busy    = (state_q == StRun) || (state_q == StPause);
   assign done    = done_q;

endmodule

// File: tb/tb_ptn_seq_ctrl.sv
// Randomized scoreboard bench for ptn_seq_ctrl: an arithmetic reference model pushes the
// expected outputs for each clock edge, and a monitor pops and compares after the edge.
module tb_ptn_seq_ctrl;

   localparam int TD  = 2;
   localparam int FPD = 2;
   localparam int FRAME = 16 * TD;

   typedef struct packed {
      logic [3:0]  mode;
      logic [15:0] row;
      logic [3:0]  row_idx;
      logic        busy;
      logic        done;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        loop_en = 1'b0;
   logic [3:0]  mode;
   logic [15:0] row;
   logic [3:0]  row_idx;
   logic        busy;
   logic        done;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   lp = 1'b0;

   // Reference model: time since reset, phase (0 idle, 1 run, 2 pause, 3 done),
   // displayed digit and completed frames of the current digit.
   int m_t = 0;
   int m_ph = 0;
   int m_digit = 9;
   int m_frames = 0;

   ptn_seq_ctrl #(
      .TICK_DIV         (TD),
      .FRAMES_PER_DIGIT (FPD)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .pause   (pause),
      .loop_en (loop_en),
      .mode    (mode),
      .row     (row),
      .row_idx (row_idx),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit s, input bit p, input bit l, input bit r);
      exp_t        e;
      bit          fend;
      bit          dn;
      logic [15:0] one;
      one = 16'h0001;
      dn  = 1'b0;
      if (r) begin
         m_t = 0; m_ph = 0; m_digit = 9; m_frames = 0;
      end else begin
         fend = (m_t % FRAME) == FRAME - 1;
         case (m_ph)
            0: if (s) begin m_ph = 1; m_frames = 0; end
            1: begin
               if (fend) begin
                  m_frames++;
                  if (m_frames == FPD) begin
                     m_frames = 0;
                     if (m_digit > 4) m_digit--;
                     else if (l) m_digit = 9;
                     else begin m_ph = 3; dn = 1'b1; end
                  end
               end
               if (p && m_ph == 1) m_ph = 2;
            end
            2: if (p) m_ph = 1;
            default: if (s) begin m_digit = 9; m_frames = 0; m_ph = 1; end
         endcase
         m_t++;
      end
      e.mode    = 4'(m_digit);
      e.row_idx = 4'((m_t / TD) % 16);
      e.row     = one << e.row_idx;
      e.busy    = (m_ph == 1) || (m_ph == 2);
      e.done    = dn;
      exp_q.push_back(e);
   endtask

   task automatic cycle(input bit s, input bit p);
      @(negedge clk);
      start   = s;
      pause   = p;
      loop_en = lp;
      model_step(s, p, lp, 1'b0);
   endtask

   task automatic run(input int n, input int ps, input int pp);
      for (int i = 0; i < n; i++) begin
         cycle($urandom_range(0, 999) < ps, $urandom_range(0, 999) < pp);
      end
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      rst = 1'b1; start = 1'b0; pause = 1'b0;
      #1;
      chk("rst_mode", 32'(mode), 32'd9);
      chk("rst_row", 32'(row), 32'h0001);
      chk("rst_row_idx", 32'(row_idx), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      model_step(1'b0, 1'b0, lp, 1'b1);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         model_step(1'b0, 1'b0, lp, 1'b1);
      end
      @(negedge clk);
      rst = 1'b0;
      loop_en = lp;
      model_step(1'b0, 1'b0, lp, 1'b0);
   endtask

   task automatic ensure_run();
      if (m_ph == 2) cycle(1'b0, 1'b1);
      else if (m_ph != 1) cycle(1'b1, 1'b0);
   endtask

   task automatic wait_digit(input int d, input int budget);
      int k;
      k = 0;
      while ((m_digit != d || m_ph != 1) && k < budget) begin
         cycle(1'b0, 1'b0);
         k++;
      end
      n_vec++;
      if (k >= budget) begin
         n_err++;
         $display("FAIL wait_digit_%0d: timed out after %0d cycles", d, budget);
      end
   endtask

   // Monitor: compares the DUT against the oldest expectation one step after each edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mode", 32'(mode), 32'(e.mode));
            chk("row", 32'(row), 32'(e.row));
            chk("row_idx", 32'(row_idx), 32'(e.row_idx));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("done", 32'(done), 32'(e.done));
         end
      end
   end

   initial begin
      int k;
      do_reset(3);
      // Idle row walk; pause pulses must be ignored.
      run(80, 0, 30);
      // Full non-looping countdown.
      lp = 1'b0;
      cycle(1'b1, 1'b0);
      run(450, 0, 0);
      // Restart from DONE, then stray starts while running.
      cycle(1'b1, 1'b0);
      run(60, 30, 0);
      // Looping, then drop loop_en.
      lp = 1'b1;
      run(900, 0, 0);
      lp = 1'b0;
      run(450, 0, 0);
      // Pause at digit 7 for 200 cycles.
      ensure_run();
      wait_digit(7, 600);
      cycle(1'b0, 1'b1);
      run(200, 0, 0);
      cycle(1'b0, 1'b1);
      run(300, 0, 0);
      // Pause coincident with a dwell-expiry frame end.
      ensure_run();
      k = 0;
      while (!(m_ph == 1 && m_digit > 4 && m_frames == FPD - 1 &&
               (m_t % FRAME) == FRAME - 1) && k < 400) begin
         cycle(1'b0, 1'b0);
         k++;
      end
      n_vec++;
      if (k >= 400) begin
         n_err++;
         $display("FAIL collision_wait: no expiry edge within 400 cycles");
      end
      cycle(1'b0, 1'b1);
      run(50, 0, 0);
      cycle(1'b0, 1'b1);
      run(100, 0, 0);
      // Random mix of start, pause and loop_en changes.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) < 5) lp = ~lp;
         run(1, 20, 20);
      end
      // Reset in the middle of digit 6.
      lp = 1'b0;
      do_reset(2);
      cycle(1'b1, 1'b0);
      wait_digit(6, 400);
      run(10, 0, 0);
      do_reset(2);
      run(200, 0, 0);
      @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
